// File: rtl/counter_seq_ctrl.sv
// Run controller for the 4-bit up-counter datapath.
// Sequences one counting run (start / pause / stop) against a limit latched
// at start, in one-shot or auto-reload mode. The count advances once every
// PRESCALE clocks. All outputs come straight from flops.
//
// state  | meaning
// S_IDLE | no run active; COUNT holds its last value (0 or the reached limit)
// S_RUN  | prescaler advancing, COUNT ticks toward lim_q
// S_PAUSE| run frozen by HOLD; COUNT and prescaler keep their values
module counter_seq_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             hold_i,
  input  logic             reload_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int PSC_W = $clog2(PRESCALE) + 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   count_d;
  logic [WIDTH-1:0]   lim_q;
  logic [PSC_W-1:0]   psc_q;
  logic [PSC_W-1:0]   psc_d;
  logic               rl_q;
  logic               busy_q;
  logic               done_q;
  logic               tick;

  // Incremented values and the prescaler terminal compare.
  always_comb begin
    count_d = count_q + 1'b1;
    psc_d   = psc_q + 1'b1;
    tick    = (psc_q == PSC_MAX);
  end

  // Run FSM: STOP beats START beats HOLD beats the prescaler tick.
  // Leaving S_PAUSE advances on the same edge, so each HOLD cycle costs
  // exactly one cycle of delay.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      psc_q   <= '0;
      lim_q   <= '0;
      rl_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (stop_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      psc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (start_i) begin
      lim_q   <= limit_i;
      rl_q    <= reload_i;
      count_q <= '0;
      psc_q   <= '0;
      if (limit_i != '0) begin
        state_q <= S_RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        // zero-length run: report completion immediately, never go busy
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        if (hold_i) begin
          state_q <= S_PAUSE;
        end else begin
          state_q <= S_RUN;
          if (!tick) begin
            psc_q <= psc_d;
          end else begin
            psc_q <= '0;
            if (count_q != lim_q) begin
              count_q <= count_d;
              if (count_d == lim_q) begin
                done_q <= 1'b1;
                if (!rl_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end else begin
              // reload mode: the tick after reaching the limit wraps to 0
              count_q <= '0;
            end
          end
        end
      end
    end
  end

  assign count_o = count_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl. Two instances share the stimulus:
// u_p1 runs with PRESCALE=1 and u_p2 with PRESCALE=2; each step pushes the
// expected {COUNT,BUSY,DONE} of the selected instance and pops it after the edge.
module tb_counter_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       hold;
  logic       reload;
  logic [3:0] limit;
  logic [3:0] cnt1, cnt2;
  logic       busy1, busy2, done1, done2;

  typedef logic [5:0] exp_t;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   sel   = 1'b0;

  counter_seq_ctrl #(.WIDTH(4), .PRESCALE(1)) u_p1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .hold_i(hold), .reload_i(reload), .limit_i(limit),
    .count_o(cnt1), .busy_o(busy1), .done_o(done1)
  );

  counter_seq_ctrl #(.WIDTH(4), .PRESCALE(2)) u_p2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .hold_i(hold), .reload_i(reload), .limit_i(limit),
    .count_o(cnt2), .busy_o(busy2), .done_o(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_pop(input string tag);
    exp_t got;
    exp_t e;
    got = sel ? {cnt2, busy2, done2} : {cnt1, busy1, done1};
    e   = exp_q.pop_front();
    n_cmp++;
    assert (got === e) else begin
      n_err++;
      $error("FAIL %s: observed cnt=%0d busy=%b done=%b expected cnt=%0d busy=%b done=%b",
             tag, got[5:2], got[1], got[0], e[5:2], e[1], e[0]);
    end
  endtask

  // expectation for right now, without a clock edge
  task automatic check_now(input string tag, input logic [3:0] c, input logic b, input logic d);
    exp_q.push_back({c, b, d});
    check_pop(tag);
  endtask

  // expectation for just after the next rising edge
  task automatic step(input string tag, input logic [3:0] c, input logic b, input logic d);
    exp_q.push_back({c, b, d});
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  task automatic drive(input logic st, input logic sp, input logic hd,
                       input logic rl, input logic [3:0] lm);
    start  = st;
    stop   = sp;
    hold   = hd;
    reload = rl;
    limit  = lm;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 4'd0);
    #2;
    sel = 1'b0; check_now("reset_p1", 4'd0, 0, 0);
    sel = 1'b1; check_now("reset_p2", 4'd0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // one-shot, PRESCALE=1, LIMIT=5
    sel = 1'b0;
    drive(1, 0, 0, 0, 4'd5);
    step("os_start", 4'd0, 1, 0);
    drive(0, 0, 0, 0, 4'd5);
    for (int k = 1; k <= 4; k++) step("os_count", 4'(k), 1, 0);
    step("os_done", 4'd5, 0, 1);
    step("os_hold_val", 4'd5, 0, 0);
    hold = 1'b1;
    step("idle_hold_ignored", 4'd5, 0, 0);
    hold = 1'b0;

    // auto-reload, PRESCALE=2, LIMIT=3
    sel = 1'b1;
    drive(1, 0, 0, 1, 4'd3);
    step("rl_start", 4'd0, 1, 0);
    drive(0, 0, 0, 0, 4'd7);
    for (int k = 1; k <= 16; k++)
      step("rl_seq", 4'((k / 2) % 4), 1, ((k % 8) == 6));
    stop = 1'b1;
    step("rl_stop", 4'd0, 0, 0);
    stop = 1'b0;
    step("rl_stopped", 4'd0, 0, 0);

    // pause, PRESCALE=1, LIMIT=10, HOLD for 4 cycles at COUNT=3
    sel = 1'b0;
    drive(1, 0, 0, 0, 4'd10);
    step("ps_start", 4'd0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) step("ps_pre", 4'(k), 1, 0);
    hold = 1'b1;
    for (int k = 0; k < 4; k++) step("ps_frozen", 4'd3, 1, 0);
    hold = 1'b0;
    for (int k = 4; k <= 9; k++) step("ps_post", 4'(k), 1, 0);
    step("ps_done", 4'd10, 0, 1);

    // restart at COUNT=6 with a shorter limit, then a zero-length run
    drive(1, 0, 0, 0, 4'd9);
    step("rs_start9", 4'd0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) step("rs_count", 4'(k), 1, 0);
    drive(1, 0, 0, 0, 4'd2);
    step("rs_restart", 4'd0, 1, 0);
    start = 1'b0;
    step("rs_c1", 4'd1, 1, 0);
    step("rs_done", 4'd2, 0, 1);
    step("rs_after", 4'd2, 0, 0);
    drive(1, 0, 0, 0, 4'd0);
    step("zero_done", 4'd0, 0, 1);
    start = 1'b0;
    step("zero_after", 4'd0, 0, 0);
    step("zero_idle", 4'd0, 0, 0);

    // STOP and START together: STOP wins
    drive(1, 0, 0, 0, 4'd9);
    step("pr_start", 4'd0, 1, 0);
    start = 1'b0;
    step("pr_c1", 4'd1, 1, 0);
    step("pr_c2", 4'd2, 1, 0);
    drive(1, 1, 0, 0, 4'd9);
    step("pr_stop_start", 4'd0, 0, 0);
    drive(0, 0, 0, 0, 4'd9);
    step("pr_idle", 4'd0, 0, 0);

    // STOP on the terminal tick suppresses DONE
    drive(1, 0, 0, 0, 4'd3);
    step("st_start", 4'd0, 1, 0);
    start = 1'b0;
    step("st_c1", 4'd1, 1, 0);
    step("st_c2", 4'd2, 1, 0);
    stop = 1'b1;
    step("st_term_stop", 4'd0, 0, 0);
    stop = 1'b0;
    step("st_idle", 4'd0, 0, 0);

    // START on the terminal tick restarts with no DONE
    drive(1, 0, 0, 0, 4'd2);
    step("sr_start", 4'd0, 1, 0);
    start = 1'b0;
    step("sr_c1", 4'd1, 1, 0);
    drive(1, 0, 0, 0, 4'd4);
    step("sr_term_start", 4'd0, 1, 0);
    drive(0, 1, 0, 0, 4'd4);
    step("sr_stop", 4'd0, 0, 0);
    stop = 1'b0;

    // full-scale limit, LIMIT changes mid-run are ignored
    drive(1, 0, 0, 0, 4'd15);
    step("max_start", 4'd0, 1, 0);
    drive(0, 0, 0, 1, 4'd3);
    for (int k = 1; k <= 14; k++) step("max_count", 4'(k), 1, 0);
    step("max_done", 4'd15, 0, 1);
    step("max_nowrap", 4'd15, 0, 0);
    step("max_hold", 4'd15, 0, 0);

    // asynchronous reset mid-run at COUNT=7, restart right after release
    drive(1, 0, 0, 0, 4'd12);
    step("ar_start", 4'd0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) step("ar_count", 4'(k), 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("ar_async", 4'd0, 0, 0);
    drive(1, 0, 0, 0, 4'd2);
    #2;
    rst_n = 1'b1;
    step("ar_first_start", 4'd0, 1, 0);
    start = 1'b0;
    step("ar_c1", 4'd1, 1, 0);
    step("ar_done", 4'd2, 0, 1);
    step("ar_idle", 4'd2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Run controller for the team's 4-bit up-counter datapath. It sequences one counting run: start, pause and stop commands, a programmable terminal value latched at start, and one-shot or auto-reload operation. It also provides a prescaler so the count advances every PRESCALE clocks. The block holds the counter register itself and sits between software/test control strobes and anything consuming the count or the done pulse.

## Interface
- WIDTH, 4, counter and limit width in bits
- PRESCALE, 1, clocks per count tick (≥1); prescaler width is $clog2(PRESCALE)+1

- CLK  in  1  clock, all state changes on rising edge
- RST  in  1  asynchronous, active-low reset
- START  in  1  level-sampled each edge; begin (or restart) a run
- STOP  in  1  abort run, return to IDLE
- HOLD  in  1  freeze count and prescaler while high during a run
- RELOAD  in  1  mode, sampled only with START: 1 = auto-reload, 0 = one-shot
- LIMIT  in  WIDTH  terminal count, sampled only with START
- COUNT  out  WIDTH  current count, registered
- BUSY  out  1  high in RUN or PAUSED
- DONE  out  1  one-cycle pulse each time COUNT reaches the latched limit

## Operation
- Reset (RST=0, async): state IDLE, COUNT=0, BUSY=0, DONE=0, prescaler=0, lim_q=0, rl_q=0.
- States: IDLE, RUN, PAUSED.
- Command priority, every edge: STOP > START > HOLD > tick.
- STOP, any state: next state IDLE, COUNT=0, prescaler=0, DONE=0 (no pulse).
- START, any state, no STOP:
  - Latch lim_q=LIMIT, rl_q=RELOAD.
  - Set COUNT=0 and prescaler=0.
  - If LIMIT≠0: next state RUN, BUSY=1.
  - If LIMIT=0: DONE=1 for one cycle, state IDLE, BUSY=0 (zero-length run).
  - START during RUN/PAUSED restarts the run and gives no DONE for the aborted run.
- RUN:
  - HOLD=1: next state PAUSED, nothing advances.
  - Otherwise the prescaler increments; at PRESCALE-1 it wraps to 0 and a tick occurs.
- Tick in RUN:
  - If COUNT≠lim_q: COUNT+1. If the new value equals lim_q, DONE=1 on that same edge.
  - One-shot: the edge where COUNT becomes lim_q also moves state to IDLE, BUSY=0. COUNT holds lim_q in IDLE until the next START or STOP.
  - Reload: state stays RUN. The tick after COUNT=lim_q loads COUNT=0 with no DONE. The sequence is 0,1,…,L,0,1,…, a period of (L+1) ticks.
- PAUSED: COUNT and prescaler frozen, BUSY=1. HOLD=0 returns to RUN; the prescaler resumes from its frozen value.
- HOLD in IDLE is ignored. LIMIT/RELOAD changes outside a START edge have no effect.
- Width rule: lim_q ≤ 2^WIDTH−1, so COUNT never wraps past all-ones. The only wrap is the reload to 0.

## Timing
- All outputs are registered; there is no combinational input→output path.
- START sampled at edge E: BUSY=1 and COUNT=0 visible after E.
- First tick at edge E+PRESCALE.
- One-shot, LIMIT=L>0: COUNT=L and DONE=1 after edge E+L·PRESCALE. BUSY falls on that same edge. DONE drops after the next edge.
- Reload: DONE pulses every (L+1)·PRESCALE cycles after the first.
- HOLD sampled high at edge H: the edge-H advance is suppressed. Each cycle of HOLD adds exactly one cycle to all later events.
- STOP and START coincident with a terminal tick: the command wins, and no DONE is produced.
- RST asserted mid-run: outputs go to reset values immediately, without waiting for a clock. The first START is honoured at the first rising edge after RST deasserts.

## Test plan
- Reset/one-shot, PRESCALE=1: START=1 for one cycle with LIMIT=5, RELOAD=0 → COUNT steps 0..5; DONE high exactly the cycle COUNT=5, 5 cycles after START; BUSY falls with it; COUNT holds 5.
- Reload, PRESCALE=2: LIMIT=3, RELOAD=1 → COUNT 0,0,1,1,2,2,3,3,0…; DONE pulses every 8 cycles; BUSY stays 1 until STOP, then COUNT=0, BUSY=0, no DONE.
- Pause, PRESCALE=1: LIMIT=10, HOLD high for 4 cycles starting at COUNT=3 → COUNT stays 3 for those cycles; DONE arrives 14 cycles after START instead of 10.
- Restart and zero limit: START with LIMIT=9, then START with LIMIT=2 at COUNT=6 → COUNT=0, DONE 2 cycles later, single DONE total. Then START with LIMIT=0 → one DONE pulse next cycle, BUSY never rises.
- Priority and edge cases: STOP+START same cycle → IDLE, COUNT=0. STOP on the terminal tick → no DONE. LIMIT=15 one-shot → COUNT reaches 15 without wrap.
- Async reset: RST low mid-run at COUNT=7 → COUNT=0, BUSY=0, DONE=0 before the next CLK edge. After release, START at the first edge is accepted.
